// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU phase sequencer.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        HALT = 3'd0,
        FE   = 3'd1,
        E1   = 3'd2,
        MW   = 3'd3,
        E2   = 3'd4
    } seq_state_t;

    localparam int SEQ_WCNT_W = 4;

endpackage

// File: rtl/seq_wait_counter.sv
// Down-counter that paces the multiplier wait cycles between E1 and E2 of MLR.
module seq_wait_counter
    import cpu_seq_pkg::*;
#(
    parameter int W = SEQ_WCNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (load) begin
            wcnt <= load_val;
        end else if (dec) begin
            wcnt <= wcnt - 1'b1;
        end
    end

    assign zero = (wcnt == '0);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Instruction phase sequencer: one-hot FE/E1/E2 strobes, MLR wait insertion,
// run/stop/single-step control and retired-instruction counting.
module cpu_phase_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop_req,
    input  logic             step,
    input  logic             extra1,
    input  logic             is_mlr,
    input  logic             is_stp,
    output logic             fe,
    output logic             e1,
    output logic             e2,
    output logic             mul_wait,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WLOAD_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [SEQ_WCNT_W-1:0] WLOAD = SEQ_WCNT_W'(WLOAD_I);

    seq_state_t state, state_nx;
    logic       running, running_nx;
    logic       single, single_nx;
    logic       wait_load;
    logic       wait_dec;
    logic       wait_zero;

    seq_wait_counter #(.W(SEQ_WCNT_W)) u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wait_load),
        .load_val (WLOAD),
        .dec      (wait_dec),
        .zero     (wait_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HALT;
            running     <= 1'b0;
            single      <= 1'b0;
            instr_count <= '0;
        end else begin
            state   <= state_nx;
            running <= running_nx;
            single  <= single_nx;
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    // The boundary decision sees this cycle's start/stop pulses, so a stop
    // arriving in the retiring phase still halts at that boundary.
    always_comb begin
        state_nx   = state;
        running_nx = running;
        single_nx  = single;
        wait_load  = 1'b0;

        if (stop_req) running_nx = 1'b0;
        if (start)    running_nx = 1'b1;

        case (state)
            HALT: begin
                if (start) begin
                    state_nx = FE;
                end else if (step) begin
                    single_nx = 1'b1;
                    state_nx  = FE;
                end
            end
            FE: state_nx = E1;
            E1: begin
                if (is_stp) begin
                    running_nx = 1'b0;
                    single_nx  = 1'b0;
                    state_nx   = HALT;
                end else if (extra1 && is_mlr && (MUL_LAT > 1)) begin
                    wait_load = 1'b1;
                    state_nx  = MW;
                end else if (extra1) begin
                    state_nx = E2;
                end else if (single || !running_nx) begin
                    single_nx = 1'b0;
                    state_nx  = HALT;
                end else begin
                    state_nx = FE;
                end
            end
            MW: begin
                if (wait_zero) state_nx = E2;
            end
            E2: begin
                if (single || !running_nx) begin
                    single_nx = 1'b0;
                    state_nx  = HALT;
                end else begin
                    state_nx = FE;
                end
            end
            default: state_nx = HALT;
        endcase
    end

    assign wait_dec = (state == MW) && !wait_zero;

    assign fe       = (state == FE);
    assign e1       = (state == E1);
    assign e2       = (state == E2);
    assign mul_wait = (state == MW);
    assign halted   = (state == HALT);
    assign retire   = (e1 && (is_stp || !extra1)) || e2;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed self-checking bench for cpu_phase_sequencer (MUL_LAT=3 and MUL_LAT=1 instances).
module tb_cpu_phase_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop_req = 1'b0, step = 1'b0;
    logic extra1 = 1'b0, is_mlr = 1'b0, is_stp = 1'b0;

    logic fe, e1, e2, mul_wait, halted, retire;
    logic [15:0] instr_count;
    logic fe1, e1_1, e2_1, mul_wait1, halted1, retire1;
    logic [15:0] instr_count1;

    int passed = 0;
    int total  = 0;

    // Phase code {fe, e1, e2, mul_wait, halted}
    localparam logic [4:0] P_FE   = 5'b10000;
    localparam logic [4:0] P_E1   = 5'b01000;
    localparam logic [4:0] P_E2   = 5'b00100;
    localparam logic [4:0] P_MW   = 5'b00010;
    localparam logic [4:0] P_HALT = 5'b00001;

    logic [4:0] ph, ph1;
    assign ph  = {fe, e1, e2, mul_wait, halted};
    assign ph1 = {fe1, e1_1, e2_1, mul_wait1, halted1};

    always #5 clk = ~clk;

    cpu_phase_sequencer #(.MUL_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .step(step),
        .extra1(extra1), .is_mlr(is_mlr), .is_stp(is_stp),
        .fe(fe), .e1(e1), .e2(e2), .mul_wait(mul_wait), .halted(halted),
        .retire(retire), .instr_count(instr_count)
    );

    cpu_phase_sequencer #(.MUL_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req), .step(step),
        .extra1(extra1), .is_mlr(is_mlr), .is_stp(is_stp),
        .fe(fe1), .e1(e1_1), .e2(e2_1), .mul_wait(mul_wait1), .halted(halted1),
        .retire(retire1), .instr_count(instr_count1)
    );

    // Drive one cycle of inputs at the falling edge, then settle before sampling.
    task automatic cyc(input logic s, input logic sr, input logic st,
                       input logic ex, input logic ml, input logic sp);
        @(negedge clk);
        start = s; stop_req = sr; step = st; extra1 = ex; is_mlr = ml; is_stp = sp;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++; if (ph !== P_HALT) $display("[TB] FAIL reset_phase: got %b want %b", ph, P_HALT); else passed++;
        total++; if (retire !== 1'b0) $display("[TB] FAIL reset_retire: got %b want 0", retire); else passed++;
        total++; if (instr_count !== 16'd0) $display("[TB] FAIL reset_count: got %0d want 0", instr_count); else passed++;
        total++; if (ph1 !== P_HALT) $display("[TB] FAIL reset_phase_lat1: got %b want %b", ph1, P_HALT); else passed++;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_HALT) $display("[TB] FAIL idle_halt: got %b want %b", ph, P_HALT); else passed++;
    endtask

    task automatic test_single_cycle();
        logic [4:0] exp_ph;
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        total++; if (ph !== P_HALT) $display("[TB] FAIL start_sample_halt: got %b want %b", ph, P_HALT); else passed++;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            exp_ph = (i % 2 == 0) ? P_FE : P_E1;
            total++; if (ph !== exp_ph) $display("[TB] FAIL single_phase%0d: got %b want %b", i, ph, exp_ph); else passed++;
            total++; if (retire !== logic'(i % 2)) $display("[TB] FAIL single_retire%0d: got %b want %b", i, retire, logic'(i % 2)); else passed++;
        end
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (instr_count !== 16'd3) $display("[TB] FAIL single_count: got %0d want 3", instr_count); else passed++;
        total++; if (ph !== P_FE) $display("[TB] FAIL single_still_running: got %b want %b", ph, P_FE); else passed++;
    endtask

    task automatic test_lda();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_FE) $display("[TB] FAIL lda_fe: got %b want %b", ph, P_FE); else passed++;
        cyc(0, 0, 0, 1, 0, 0);
        total++; if (ph !== P_E1) $display("[TB] FAIL lda_e1: got %b want %b", ph, P_E1); else passed++;
        total++; if (retire !== 1'b0) $display("[TB] FAIL lda_e1_retire: got %b want 0", retire); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_E2) $display("[TB] FAIL lda_e2: got %b want %b", ph, P_E2); else passed++;
        total++; if (retire !== 1'b1) $display("[TB] FAIL lda_e2_retire: got %b want 1", retire); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_FE) $display("[TB] FAIL lda_next_fe: got %b want %b", ph, P_FE); else passed++;
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL lda_count: got %0d want 1", instr_count); else passed++;
    endtask

    task automatic test_mlr();
        logic [4:0] exp_seq [0:5];
        logic [4:0] exp_seq1 [0:3];
        int mw_cycles;
        int mw_cycles1;
        exp_seq[0] = P_FE; exp_seq[1] = P_E1; exp_seq[2] = P_MW;
        exp_seq[3] = P_MW; exp_seq[4] = P_E2; exp_seq[5] = P_FE;
        exp_seq1[0] = P_FE; exp_seq1[1] = P_E1; exp_seq1[2] = P_E2; exp_seq1[3] = P_FE;
        mw_cycles = 0;
        mw_cycles1 = 0;
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 1) cyc(0, 0, 0, 1, 1, 0);
            else        cyc(0, 0, 0, 0, 0, 0);
            if (mul_wait === 1'b1) mw_cycles++;
            if (i < 4 && mul_wait1 === 1'b1) mw_cycles1++;
            total++; if (ph !== exp_seq[i]) $display("[TB] FAIL mlr3_phase%0d: got %b want %b", i, ph, exp_seq[i]); else passed++;
            if (i < 4) begin
                total++; if (ph1 !== exp_seq1[i]) $display("[TB] FAIL mlr1_phase%0d: got %b want %b", i, ph1, exp_seq1[i]); else passed++;
            end
            if (i == 3) begin
                total++; if (instr_count1 !== 16'd1) $display("[TB] FAIL mlr1_count: got %0d want 1", instr_count1); else passed++;
            end
        end
        total++; if (mw_cycles != 2) $display("[TB] FAIL mlr3_mw_cycles: got %0d want 2", mw_cycles); else passed++;
        total++; if (mw_cycles1 != 0) $display("[TB] FAIL mlr1_mw_cycles: got %0d want 0", mw_cycles1); else passed++;
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL mlr3_count: got %0d want 1", instr_count); else passed++;
    endtask

    task automatic test_stp();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        total++; if (ph !== P_E1) $display("[TB] FAIL stp_e1: got %b want %b", ph, P_E1); else passed++;
        total++; if (retire !== 1'b1) $display("[TB] FAIL stp_retire: got %b want 1", retire); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_HALT) $display("[TB] FAIL stp_halt: got %b want %b", ph, P_HALT); else passed++;
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL stp_count: got %0d want 1", instr_count); else passed++;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            total++; if (halted !== 1'b1) $display("[TB] FAIL stp_stay_halt%0d: got %b want 1", i, halted); else passed++;
        end
    endtask

    task automatic test_step();
        logic [4:0] exp_seq [0:8];
        exp_seq[0] = P_HALT; exp_seq[1] = P_FE; exp_seq[2] = P_E1; exp_seq[3] = P_MW;
        exp_seq[4] = P_MW;   exp_seq[5] = P_E2; exp_seq[6] = P_HALT; exp_seq[7] = P_HALT;
        exp_seq[8] = P_HALT;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       cyc(0, 0, 1, 0, 0, 0);
                2:       cyc(0, 0, 0, 1, 1, 0);
                3:       cyc(0, 0, 1, 0, 0, 0);
                default: cyc(0, 0, 0, 0, 0, 0);
            endcase
            total++; if (ph !== exp_seq[i]) $display("[TB] FAIL step_phase%0d: got %b want %b", i, ph, exp_seq[i]); else passed++;
        end
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL step_count: got %0d want 1", instr_count); else passed++;
    endtask

    task automatic test_stop();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        total++; if (ph !== P_E1) $display("[TB] FAIL stop_e1: got %b want %b", ph, P_E1); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_E2) $display("[TB] FAIL stop_e2_completes: got %b want %b", ph, P_E2); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_HALT) $display("[TB] FAIL stop_halt: got %b want %b", ph, P_HALT); else passed++;
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL stop_count: got %0d want 1", instr_count); else passed++;
    endtask

    task automatic test_start_priority();
        do_reset();
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_FE) $display("[TB] FAIL prio_fe: got %b want %b", ph, P_FE); else passed++;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_FE) $display("[TB] FAIL prio_keeps_running: got %b want %b", ph, P_FE); else passed++;
    endtask

    task automatic test_reset_mid_mw();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        total++; if (ph !== P_MW) $display("[TB] FAIL rstmw_in_mw: got %b want %b", ph, P_MW); else passed++;
        total++; if (instr_count !== 16'd1) $display("[TB] FAIL rstmw_pre_count: got %0d want 1", instr_count); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (halted !== 1'b1) $display("[TB] FAIL rstmw_halted: got %b want 1", halted); else passed++;
        total++; if (mul_wait !== 1'b0) $display("[TB] FAIL rstmw_mul_wait: got %b want 0", mul_wait); else passed++;
        total++; if (instr_count !== 16'd0) $display("[TB] FAIL rstmw_count: got %0d want 0", instr_count); else passed++;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_lda();
        test_mlr();
        test_stp();
        test_step();
        test_stop();
        test_start_priority();
        test_reset_mid_mw();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
